// File: rtl/fifo_stream_reader.sv
// Read-side engine for the async FIFO: issues reads, absorbs the one-cycle
// RAM latency in a 2-entry skid buffer and presents a valid/ready stream
// with first/last framing for PKT_LEN-word packets.
module fifo_stream_reader #(
  parameter int WIDTH   = 64,
  parameter int PKT_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_rddata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_first,
  output logic             m_last
);

  localparam int CW = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

  logic [WIDTH-1:0] skid [2];
  logic             head;
  logic             tail;
  logic [1:0]       occ;
  logic             inflight;
  logic [CW-1:0]    beat;
  logic             push;
  logic             pop;

  // The word returning this edge is exactly the one flagged in flight.
  assign push = inflight;
  assign pop  = m_valid && m_ready;

  // Issue a read only if, after this edge, at most one slot is taken, so the
  // new word always finds room when it lands next edge. The returning word
  // is counted once (inflight is the push), which keeps one read per cycle
  // when the head is being popped every cycle.
  always_comb begin
    fifo_rden = 1'b0;
    if (rst_n && en && !fifo_empty &&
        (({1'b0, occ} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop})))
      fifo_rden = 1'b1;
  end

  // Skid buffer pointers/occupancy, in-flight flag and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      if (push) begin
        skid[tail] <= fifo_rddata;
        tail       <= ~tail;
      end
      if (pop)
        head <= ~head;
      if (push && !pop)
        occ <= occ + 2'd1;
      else if (pop && !push)
        occ <= occ - 2'd1;
      inflight <= fifo_rden && !fifo_empty;
      if (pop)
        beat <= (beat == LAST_BEAT) ? '0 : beat + CW'(1);
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = skid[head];
  assign m_first = (beat == '0);
  assign m_last  = (beat == LAST_BEAT);

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);
  a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n) !(push && occ == 2'd2));
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> $stable(m_data));
  a_rden_empty: assert property (@(posedge clk) !(fifo_rden && fifo_empty));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a simple FIFO source, a queue-based model of
// the expected stream and framing, and directed scenarios with literal checks.
module tb_fifo_stream_reader;

  localparam int W  = 16;
  localparam int PL = 4;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         en      = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [W-1:0] fifo_rddata;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_first;
  logic         m_last;

  int n_cmp = 0;
  int n_err = 0;

  fifo_stream_reader #(.WIDTH(W), .PKT_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_first(m_first), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO: one-cycle read latency, discarded on reset
  logic [W-1:0] fmem [256];
  int unsigned  wr_ptr = 0;
  int unsigned  rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rden && !fifo_empty) begin
      fifo_rddata <= fmem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = W'(base + i);
      wr_ptr++;
    end
  endtask

  // Model: every accepted read lands in the expected stream one edge later,
  // leaves on a handshake; beat index counts handshakes modulo PL.
  typedef struct { logic [W-1:0] d; logic f; logic l; } pop_t;
  logic [W-1:0] exp_q [$];
  pop_t         plog [$];
  bit           pend = 0;
  logic [W-1:0] pend_data;
  int unsigned  mrd = 0;
  int           beats = 0;
  bit           live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend  = 0;
      beats = 0;
      mrd   = wr_ptr;
      live  = 1;
    end else begin
      if (m_valid && m_ready) begin
        plog.push_back('{m_data, m_first, m_last});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats = (beats + 1) % PL;
      end
      if (pend) begin
        chk("capacity", exp_q.size() < 2, 1);
        exp_q.push_back(pend_data);
      end
      pend = fifo_rden && !fifo_empty;
      if (pend) begin
        pend_data = fmem[mrd];
        mrd++;
      end
    end
  end

  // Per-cycle compare against the model
  bit           stall_prev = 0;
  logic [W-1:0] prev_d;
  logic         prev_f, prev_l;

  always @(negedge clk) begin
    if (live) begin
      chk("m_valid", m_valid, exp_q.size() != 0);
      if (m_valid && exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
      chk("m_first", m_first, beats == 0);
      chk("m_last", m_last, beats == PL - 1);
      if (fifo_rden) begin
        chk("rden_empty", fifo_empty, 0);
        chk("rden_en", en, 1);
        chk("rden_rst", rst_n, 1);
        if (!m_ready) chk("rden_full", exp_q.size() < 2, 1);
      end
      if (stall_prev) begin
        chk("stall_data", m_data, prev_d);
        chk("stall_first", m_first, prev_f);
        chk("stall_last", m_last, prev_l);
      end
      stall_prev = m_valid && !m_ready && rst_n;
      prev_d = m_data;
      prev_f = m_first;
      prev_l = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_pops(input string tag, input int base_idx, input int n,
                          input int base_val, input logic [15:0] fmask,
                          input logic [15:0] lmask);
    chk({tag, "_count"}, plog.size() >= base_idx + n, 1);
    if (plog.size() >= base_idx + n) begin
      for (int k = 0; k < n; k++) begin
        chk({tag, "_data"}, plog[base_idx + k].d, W'(base_val + k));
        chk({tag, "_first"}, plog[base_idx + k].f, fmask[k]);
        chk({tag, "_last"}, plog[base_idx + k].l, lmask[k]);
      end
    end
  endtask

  initial begin
    logic [11:0]  rdv, vv;
    logic [W-1:0] dv [12];
    int           b;

    // Reset hold then release with the FIFO empty
    run(3);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_valid", m_valid, 0);
      chk("t1_rden", fifo_rden, 0);
      chk("t1_first", m_first, 1);
      chk("t1_last", m_last, 0);
    end

    // Back-to-back streaming of 0..7
    step();
    b = plog.size();
    load(0, 8);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdv[i] = fifo_rden;
      vv[i]  = m_valid;
      dv[i]  = m_data;
    end
    chk("t2_rden_run", rdv, 12'h0FF);
    chk("t2_valid_run", vv, 12'h3FC);
    for (int i = 2; i < 10; i++) chk("t2_data_seq", dv[i], W'(i - 2));
    chk_pops("t2", b, 8, 0, 16'h0011, 16'h0088);

    // Framing over 10 words
    step();
    b = plog.size();
    load(100, 10);
    run(16);
    chk_pops("t3", b, 10, 100, 16'h0111, 16'h0088);
    chk("t3_beat_after", beats, 2);

    // Back-pressure pattern 1,0,0,1,0,1,1,1 on 6 words
    b = plog.size();
    load(200, 6);
    for (int i = 0; i < 8; i++) begin
      m_ready = (8'b1110_1001 >> i) & 8'd1;
      step();
    end
    m_ready = 1'b1;
    run(10);
    chk_pops("t4", b, 6, 200, 16'h0004, 16'h0022);
    chk("t4_exact", plog.size() - b, 6);

    // en dropped right after an accepted read
    b = plog.size();
    load(300, 4);
    step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_rden_off", fifo_rden, 0);
      step();
    end
    chk("t5_one_more", plog.size() - b, 1);
    chk_pops("t5a", b, 1, 300, 16'h0001, 16'h0000);
    en = 1'b1;
    run(10);
    chk_pops("t5b", b + 1, 3, 301, 16'h0000, 16'h0004);

    // Reset with one word buffered and one in flight
    b = plog.size();
    m_ready = 1'b0;
    load(400, 6);
    run(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid", m_valid, 0);
    chk("t6_first", m_first, 1);
    chk("t6_rden", fifo_rden, 0);
    chk("t6_none", plog.size() - b, 0);
    step();
    load(500, 4);
    m_ready = 1'b1;
    run(10);
    chk_pops("t6", b, 4, 500, 16'h0001, 16'h0008);
    chk("t6_exact", plog.size() - b, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
